// File: rtl/timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_pkg                                                            |
// | Register map and reset constants shared by the machine timer.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package timer_pkg;

  typedef enum logic [1:0] {
    MTIME_LO    = 2'd0,
    MTIME_HI    = 2'd1,
    MTIMECMP_LO = 2'd2,
    MTIMECMP_HI = 2'd3
  } timer_reg_e;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // Replace one 32-bit half of a 64-bit register, keeping the other half.
  function automatic logic [63:0] write_half(input logic [63:0] old_val,
                                             input logic        hi,
                                             input logic [31:0] data);
    logic [63:0] res;
    res = old_val;
    if (hi) res[63:32] = data;
    else    res[31:0]  = data;
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter                                                              |
// | Generic loadable up/down counter with carry-in and carry/borrow out. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module counter #(
  parameter int Width     = 8,
  parameter int Increment = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up0_down1,
  input  logic             carry_in,
  input  logic             load,
  input  logic [Width-1:0] load_count,
  output logic [Width-1:0] count,
  output logic             carry_out
);

  localparam int             c_w1  = Width + 1;
  localparam logic [Width:0] c_inc = c_w1'(Increment);

  logic [Width-1:0] r_count;
  logic [Width:0]   w_up;
  logic [Width:0]   w_dn;

  // One extra bit on each path captures carry (up) or borrow (down).
  assign w_up = {1'b0, r_count} + c_inc + c_w1'(carry_in);
  assign w_dn = {1'b0, r_count} - c_inc - c_w1'(carry_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_count;
    end else if (enable) begin
      r_count <= up0_down1 ? w_dn[Width-1:0] : w_up[Width-1:0];
    end
  end

  assign count     = r_count;
  assign carry_out = enable & (up0_down1 ? w_dn[Width] : w_up[Width]);

endmodule
`default_nettype wire

// File: rtl/machine_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | machine_timer                                                        |
// | RISC-V mtime/mtimecmp with prescaled tick and level timer interrupt. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module machine_timer
  import timer_pkg::*;
#(
  parameter int TickDiv       = 1,
  parameter int PrescaleWidth = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_en,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        irq
);

  localparam logic [PrescaleWidth-1:0] c_tick_last = PrescaleWidth'(TickDiv - 1);

  logic [63:0]              r_mtime;
  logic [63:0]              r_mtimecmp;
  logic [31:0]              r_hi_shadow;
  logic                     r_resp_valid;
  logic [31:0]              r_resp_rdata;
  logic                     r_irq;

  logic [PrescaleWidth-1:0] w_count;
  logic                     w_unused_carry;
  logic                     w_tick;
  timer_reg_e               w_addr;
  logic                     w_wr;
  logic                     w_rd;
  logic                     w_mtime_wr;
  logic                     w_cmp_wr;
  logic [63:0]              w_mtime_next;
  logic [63:0]              w_cmp_next;
  logic [31:0]              w_rdata;

  assign w_addr     = timer_reg_e'(req_addr);
  assign w_wr       = req_valid & req_write;
  assign w_rd       = req_valid & ~req_write;
  assign w_mtime_wr = w_wr & ((w_addr == MTIME_LO) | (w_addr == MTIME_HI));
  assign w_cmp_wr   = w_wr & ((w_addr == MTIMECMP_LO) | (w_addr == MTIMECMP_HI));

  assign w_tick = tick_en & (w_count == c_tick_last);

  // A software write to mtime restarts the prescaler phase.
  counter #(
    .Width     (PrescaleWidth),
    .Increment (1)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .enable     (tick_en),
    .up0_down1  (1'b0),
    .carry_in   (1'b0),
    .load       (w_tick | w_mtime_wr),
    .load_count ({PrescaleWidth{1'b0}}),
    .count      (w_count),
    .carry_out  (w_unused_carry)
  );

  // A write to mtime suppresses that cycle's increment entirely.
  always_comb begin
    w_mtime_next = r_mtime;
    if (w_mtime_wr) begin
      w_mtime_next = write_half(r_mtime, req_addr[0], req_wdata);
    end else if (w_tick) begin
      w_mtime_next = r_mtime + 64'd1;
    end
  end

  always_comb begin
    w_cmp_next = r_mtimecmp;
    if (w_cmp_wr) begin
      w_cmp_next = write_half(r_mtimecmp, req_addr[0], req_wdata);
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_addr)
      MTIME_LO:    w_rdata = r_mtime[31:0];
      MTIME_HI:    w_rdata = r_hi_shadow;
      MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
      MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtime      <= '0;
      r_mtimecmp   <= MTIMECMP_RESET;
      r_hi_shadow  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_mtime      <= w_mtime_next;
      r_mtimecmp   <= w_cmp_next;
      r_irq        <= (w_mtime_next >= w_cmp_next);
      if (w_rd && (w_addr == MTIME_LO)) begin
        r_hi_shadow <= r_mtime[63:32];
      end
      r_resp_valid <= req_valid;
      r_resp_rdata <= w_rd ? w_rdata : 32'd0;
    end
  end

  assign req_ready  = 1'b1;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign irq        = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_machine_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_machine_timer                                                     |
// | Directed bench: TickDiv=4 instance (0) and TickDiv=1 instance (1).   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_machine_timer;
  import timer_pkg::*;

  logic        clk;
  logic        rst;
  logic        tick_en    [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [1:0]  req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        irq        [2];

  int n_vec  = 0;
  int n_miss = 0;

  machine_timer #(.TickDiv(4), .PrescaleWidth(8)) u_dut4 (
    .clk(clk), .rst(rst), .tick_en(tick_en[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .irq(irq[0])
  );

  machine_timer #(.TickDiv(1), .PrescaleWidth(8)) u_dut1 (
    .clk(clk), .rst(rst), .tick_en(tick_en[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .irq(irq[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_op(input int d, input logic wr, input logic [1:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wd;
    step();
    req_valid[d] = 1'b0;
    req_write[d] = 1'b0;
    check($sformatf("resp_valid[%0d]", d), resp_valid[d], 1);
    rd = resp_rdata[d];
  endtask

  task automatic reg_wr(input int d, input logic [1:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    reg_op(d, 1'b1, addr, wd, rd);
    check($sformatf("wr_rdata[%0d]", d), rd, 0);
  endtask

  task automatic reg_rd(input int d, input logic [1:0] addr, input logic [31:0] exp,
                        input string tag);
    logic [31:0] rd;
    reg_op(d, 1'b0, addr, 32'd0, rd);
    check(tag, rd, exp);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick_en[i]   = 1'b1;
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = 2'd0;
      req_wdata[i] = 32'd0;
    end
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_irq[%0d]", i), irq[i], 0);
      check($sformatf("rst_rv[%0d]", i), resp_valid[i], 0);
      check($sformatf("rst_rdata[%0d]", i), resp_rdata[i], 0);
    end
    check("req_ready", req_ready[1], 1);
    rst = 1'b0;

    // TickDiv=4: 16 edges give 4 ticks.
    repeat (16) step();
    reg_rd(0, MTIME_LO, 32'd4, "div4_mtime_lo");
    reg_rd(0, MTIME_HI, 32'd0, "div4_mtime_hi");
    reg_rd(0, MTIMECMP_LO, 32'hFFFF_FFFF, "div4_cmp_lo");
    check("div4_irq", irq[0], 0);
    tick_en[0] = 1'b0;

    // Carry from lo into hi.
    reg_wr(1, MTIME_LO, 32'hFFFF_FFFE);
    reg_wr(1, MTIME_HI, 32'd0);
    repeat (3) step();
    check("rv_idle", resp_valid[1], 0);
    reg_rd(1, MTIME_LO, 32'd1, "carry_lo");
    reg_rd(1, MTIME_HI, 32'd1, "carry_hi");

    // irq rises when mtime reaches mtimecmp, falls on a mtimecmp write.
    tick_en[1] = 1'b0;
    reg_wr(1, MTIMECMP_LO, 32'd10);
    reg_wr(1, MTIMECMP_HI, 32'd0);
    reg_wr(1, MTIME_HI, 32'd0);
    reg_wr(1, MTIME_LO, 32'd0);
    check("irq_zero", irq[1], 0);
    tick_en[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k >= 9) check($sformatf("irq_at_%0d", k), irq[1], (k >= 10) ? 1 : 0);
    end
    reg_wr(1, MTIMECMP_LO, 32'd100);
    check("irq_fall", irq[1], 0);

    // hi reads return the snapshot taken by the lo read.
    tick_en[1] = 1'b0;
    reg_wr(1, MTIME_HI, 32'd0);
    reg_wr(1, MTIME_LO, 32'd5);
    tick_en[1] = 1'b1;
    reg_rd(1, MTIME_LO, 32'd5, "snap_lo5");
    repeat (3) step();
    reg_rd(1, MTIME_HI, 32'd0, "snap_hi0");
    tick_en[1] = 1'b0;
    reg_wr(1, MTIME_HI, 32'd1);
    reg_wr(1, MTIME_LO, 32'hFFFF_FFFF);
    tick_en[1] = 1'b1;
    reg_rd(1, MTIME_LO, 32'hFFFF_FFFF, "snap_lo_ff");
    reg_rd(1, MTIME_HI, 32'd1, "snap_hi1");
    check("irq_big", irq[1], 1);

    // Write to mtime wins over a same-cycle tick.
    reg_wr(1, MTIME_LO, 32'd7);
    tick_en[1] = 1'b0;
    reg_rd(1, MTIME_LO, 32'd7, "wrwin_lo");
    reg_rd(1, MTIME_HI, 32'd2, "wrwin_hi");
    repeat (10) step();
    reg_rd(1, MTIME_LO, 32'd7, "frozen_lo");
    reg_rd(1, MTIME_HI, 32'd2, "frozen_hi");

    // mtimecmp write and tick in the same cycle both land.
    tick_en[1] = 1'b1;
    reg_wr(1, MTIMECMP_HI, 32'd5);
    check("cmp_tick_irq", irq[1], 0);
    tick_en[1] = 1'b0;
    reg_rd(1, MTIME_LO, 32'd8, "cmp_tick_lo");
    reg_rd(1, MTIMECMP_HI, 32'd5, "cmp_tick_hi");
    reg_wr(1, MTIMECMP_HI, 32'd0);
    check("cmp_lower_irq", irq[1], 1);

    // Reset with a read in flight.
    reg_rd(1, MTIME_LO, 32'd8, "pre_rst_lo");
    req_valid[1] = 1'b1;
    req_write[1] = 1'b0;
    req_addr[1]  = MTIMECMP_HI;
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_rv", resp_valid[1], 0);
    check("mid_rst_rdata", resp_rdata[1], 0);
    check("mid_rst_irq", irq[1], 0);
    step();
    req_valid[1] = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("post_rst_rv%0d", k), resp_valid[1], 0);
    end
    reg_rd(1, MTIMECMP_LO, 32'hFFFF_FFFF, "post_rst_cmp_lo");
    reg_rd(1, MTIME_LO, 32'd0, "post_rst_mtime_lo");
    reg_rd(1, MTIMECMP_HI, 32'hFFFF_FFFF, "post_rst_cmp_hi");
    check("post_rst_irq", irq[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/machine_timer.md
# machine_timer

Memory-mapped RISC-V machine timer: a 64-bit `mtime` advanced by a programmable-rate prescaler, a 64-bit `mtimecmp`, and a level machine-timer interrupt. It sits downstream of the generic `counter`, which it uses as its prescaler tick source. It sits upstream of the CPU's CSR/interrupt logic, which consumes `irq`. Software accesses it over a 32-bit single-beat register port.

## Interface
- `TickDiv`, default 1: clk cycles per `mtime` increment while `tick_en` is high. Legal range 1..255.
- `PrescaleWidth`, default 8: width of the prescaler count. Must hold `TickDiv-1`.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `tick_en` in 1: global count enable; low freezes the prescaler and `mtime`.
- `req_valid` in 1: register request present.
- `req_ready` out 1: always 1; every valid request is accepted in its cycle.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 2: 0 = mtime_lo, 1 = mtime_hi, 2 = mtimecmp_lo, 3 = mtimecmp_hi.
- `req_wdata` in 32: write data.
- `resp_valid` out 1: one-cycle pulse, one cycle after each accepted request (reads and writes).
- `resp_rdata` out 32: read data, valid with `resp_valid`; 0 for write responses.
- `irq` out 1: registered, level, (`mtime` >= `mtimecmp`) unsigned.

## Operation
- Reset values:
  - `mtime` = 0, `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, prescaler = 0, hi_shadow = 0.
  - `irq` = 0, `resp_valid` = 0, `resp_rdata` = 0.
- Prescaler:
  - Counts up while `tick_en`=1.
  - When the count equals `TickDiv-1` and `tick_en`=1: a tick is generated and the count reloads to 0 in the same edge.
  - `TickDiv`=1 gives a tick every enabled cycle.
- Tick: `mtime` <= `mtime` + 1 as a full 64-bit add. Carry propagates from lo to hi in the same edge; 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- Writes:
  - Replace the addressed 32-bit half. The other half is unchanged.
  - A write to either `mtime` half reloads the prescaler to 0.
- Simultaneous write to an `mtime` half and tick: the write wins. The untouched half keeps its old value, with no increment and no carry that cycle.
- Simultaneous write to `mtimecmp` and tick: both take effect.
- Reads:
  - Reading mtime_lo returns `mtime`[31:0] and snapshots `mtime`[63:32] into hi_shadow.
  - Reading mtime_hi returns hi_shadow, not the live value. Software reads lo then hi for an atomic 64-bit value.
  - Reading mtimecmp halves returns live values.
  - Read data reflects register state before any same-cycle tick.
- `irq`:
  - Updated every cycle from next-state values: `irq` <= (mtime_next >= mtimecmp_next).
  - Deasserts only by raising `mtimecmp` or lowering `mtime`.
- `rst` mid-operation: all state returns to reset values immediately. An in-flight response is dropped, with no `resp_valid` after reset release for a pre-reset request.

## Timing
- Register access latency: 1 cycle. Back-to-back requests give back-to-back `resp_valid` pulses.
- Tick to `mtime` visible: the same edge.
- `mtime` reaching `mtimecmp` to `irq` high: the same edge. There are no extra pipeline stages.
- Write to `mtimecmp` to `irq` update: the same edge as the write.
- After `rst` deasserts with `tick_en`=1, the first tick occurs on the `TickDiv`-th rising edge.

## Structure
- Shared package `timer_pkg`:
  - Address enum `timer_reg_e` (MTIME_LO, MTIME_HI, MTIMECMP_LO, MTIMECMP_HI).
  - Constant `MTIMECMP_RESET`.
- Sub-module: one `counter` instance as the prescaler.
  - Parameters: Width=`PrescaleWidth`, Increment=1.
  - Connections: `up0_down1`=0, `carry_in`=0, `enable`=`tick_en`.
  - Reload: `load` = tick OR `mtime` write, with `load_count`=0.
  - Tick is decoded combinationally from `count` == `TickDiv-1` and `tick_en`.
- `mtime`, `mtimecmp`, hi_shadow, response register and `irq` are local flops.

## Test plan
- Reset, then `tick_en`=1 with `TickDiv`=4 for 16 cycles: `mtime` reads 4; `irq`=0; a mtimecmp_lo read returns 32'hFFFF_FFFF.
- Write mtime_lo=32'hFFFF_FFFE and mtime_hi=0, with `TickDiv`=1, for 3 cycles: reading lo then hi yields 64'h1_0000_0001. Verify the carry into hi.
- Set `mtimecmp`=10 and `mtime`=0, with `TickDiv`=1: `irq` rises on the edge where `mtime` becomes 10. Then write mtimecmp_lo=100: `irq` falls on that write's edge.
- Read mtime_lo (value 5), let 3 ticks pass, then read mtime_hi: hi returns the snapshot, not the live value. A forced test with `mtime`=64'h0000_0001_FFFF_FFFF confirms the snapshot is 1.
- With `TickDiv`=1, write mtime_lo=7 in a cycle where a tick occurs: `mtime`[31:0]=7, not 8. Also verify `tick_en`=0 for 10 cycles holds `mtime` constant.
- Assert `rst` one cycle after a read request: no `resp_valid` appears and all outputs return to reset values; `resp_valid` pulses correctly for the first post-reset request.
